// File: rtl/nibble_collector_if.sv
// Character link plus word output port of the nibble collector.
// The slave side is the collector; the master side is the sender/consumer.
interface nibble_collector_if #(
    parameter int NIBBLES = 8
) ();
    logic                   go;
    logic [3:0]             character;
    logic                   character_done;
    logic [4*NIBBLES-1:0]   word_out;
    logic                   word_valid;
    logic                   word_ack;
    logic                   frame_error;
    logic [3:0]             nibble_count;

    modport slave (
        input  go,
        input  character,
        input  word_ack,
        output character_done,
        output word_out,
        output word_valid,
        output frame_error,
        output nibble_count
    );

    modport master (
        output go,
        output character,
        output word_ack,
        input  character_done,
        input  word_out,
        input  word_valid,
        input  frame_error,
        input  nibble_count
    );
endinterface

// File: rtl/nibble_collector.sv
// Reassembles go/character_done nibbles (LS first) into words with one
// slot of output buffering, back-pressure and partial-word timeout.
module nibble_collector #(
    parameter int NIBBLES = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    nibble_collector_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0]    NLAST = 4'(NIBBLES - 1);

    typedef enum logic {
        WAIT,
        ACK
    } state_t;

    state_t        state, state_n;
    logic          cd, cd_n;
    logic [W-1:0]  shreg, shreg_n;
    logic [W-1:0]  wout, wout_n;
    logic          wv, wv_n;
    logic          fe, fe_n;
    logic [3:0]    cnt, cnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          last;

    assign last = (cnt == NLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            cd    <= 1'b0;
            shreg <= '0;
            wout  <= '0;
            wv    <= 1'b0;
            fe    <= 1'b0;
            cnt   <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            cd    <= cd_n;
            shreg <= shreg_n;
            wout  <= wout_n;
            wv    <= wv_n;
            fe    <= fe_n;
            cnt   <= cnt_n;
            tcnt  <= tcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cd_n    = cd;
        shreg_n = shreg;
        wout_n  = wout;
        wv_n    = wv;
        fe_n    = 1'b0;
        cnt_n   = cnt;
        tcnt_n  = (cnt == 4'd0) ? '0 : tcnt;
        if (wv && bus.word_ack)
            wv_n = 1'b0;
        unique case (state)
            WAIT: begin
                if (bus.go) begin
                    if (!last) begin
                        shreg_n = {bus.character, shreg[W-1:4]};
                        cnt_n   = cnt + 4'd1;
                        cd_n    = 1'b1;
                        tcnt_n  = '0;
                        state_n = ACK;
                    end else if (!wv || bus.word_ack) begin
                        wout_n  = {bus.character, shreg[W-1:4]};
                        wv_n    = 1'b1;
                        cnt_n   = 4'd0;
                        cd_n    = 1'b1;
                        tcnt_n  = '0;
                        state_n = ACK;
                    end
                end else if (cnt != 4'd0) begin
                    // Idle between characters of a partial word
                    if (TIMEOUT != 0 && tcnt == TLAST) begin
                        cnt_n   = 4'd0;
                        shreg_n = '0;
                        fe_n    = 1'b1;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
            end
            ACK: begin
                if (!bus.go) begin
                    cd_n    = 1'b0;
                    state_n = WAIT;
                end
            end
        endcase
    end

    assign bus.character_done = cd;
    assign bus.word_out       = wout;
    assign bus.word_valid     = wv;
    assign bus.frame_error    = fe;
    assign bus.nibble_count   = cnt;
endmodule

// File: tb/tb_nibble_collector.sv
// Directed bench for nibble_collector: words, back-pressure, long go,
// timeout, mid-word reset and ack coinciding with the last nibble.
module tb_nibble_collector;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    nibble_collector_if #(.NIBBLES(8)) bus ();

    nibble_collector #(
        .NIBBLES(8),
        .TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        int k;
        bus.go = 1'b1;
        bus.character = n;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus.character_done && k < 40);
        chk("cd_rise", {31'd0, bus.character_done}, 32'd1);
        bus.go = 1'b0;
        tick();
        chk("cd_fall", {31'd0, bus.character_done}, 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit chk_nc);
        for (int i = 0; i < 8; i++) begin
            send_nib(w[4*i +: 4]);
            if (chk_nc)
                chk("nc_step", {28'd0, bus.nibble_count}, (i + 1) % 8);
        end
    endtask

    task automatic ack_word();
        bus.word_ack = 1'b1;
        tick();
        bus.word_ack = 1'b0;
        chk("ack_clr", {31'd0, bus.word_valid}, 32'd0);
    endtask

    initial begin
        bit any_hi;
        bit any_lo;
        int n;
        logic [31:0] w;

        reset = 1'b1;
        bus.go = 1'b0;
        bus.character = 4'h0;
        bus.word_ack = 1'b0;
        tick();
        tick();
        chk("rst_cd", {31'd0, bus.character_done}, 32'd0);
        chk("rst_wv", {31'd0, bus.word_valid}, 32'd0);
        chk("rst_fe", {31'd0, bus.frame_error}, 32'd0);
        chk("rst_wo", bus.word_out, 32'd0);
        chk("rst_nc", {28'd0, bus.nibble_count}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic word
        send_word(32'hDEADBEEF, 1'b1);
        chk("basic_wo", bus.word_out, 32'hDEADBEEF);
        chk("basic_wv", {31'd0, bus.word_valid}, 32'd1);
        ack_word();

        // Back-pressure
        send_word(32'h01234567, 1'b0);
        chk("bp_wv1", {31'd0, bus.word_valid}, 32'd1);
        w = 32'h89ABCDEF;
        for (int i = 0; i < 7; i++)
            send_nib(w[4*i +: 4]);
        bus.go = 1'b1;
        bus.character = w[31:28];
        any_hi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.character_done)
                any_hi = 1'b1;
        end
        chk("bp_stall_cd", {31'd0, any_hi}, 32'd0);
        chk("bp_stall_wo", bus.word_out, 32'h01234567);
        chk("bp_stall_nc", {28'd0, bus.nibble_count}, 32'd7);
        bus.word_ack = 1'b1;
        tick();
        bus.word_ack = 1'b0;
        chk("bp_rel_cd", {31'd0, bus.character_done}, 32'd1);
        chk("bp_rel_wv", {31'd0, bus.word_valid}, 32'd1);
        chk("bp_rel_wo", bus.word_out, 32'h89ABCDEF);
        bus.go = 1'b0;
        tick();
        chk("bp_cd_fall", {31'd0, bus.character_done}, 32'd0);
        ack_word();

        // Long go hold on the first nibble of 0x76543210
        w = 32'h76543210;
        bus.go = 1'b1;
        bus.character = w[3:0];
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.character_done && n < 40);
        chk("hold_rise", {31'd0, bus.character_done}, 32'd1);
        any_lo = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.character_done || bus.nibble_count != 4'd1)
                any_lo = 1'b1;
        end
        chk("hold_stable", {31'd0, any_lo}, 32'd0);
        bus.go = 1'b0;
        tick();
        chk("hold_fall", {31'd0, bus.character_done}, 32'd0);
        chk("hold_nc", {28'd0, bus.nibble_count}, 32'd1);
        for (int i = 1; i < 8; i++)
            send_nib(w[4*i +: 4]);
        chk("hold_wo", bus.word_out, 32'h76543210);
        ack_word();

        // Timeout on a 3-nibble partial word
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h3);
        chk("to_nc3", {28'd0, bus.nibble_count}, 32'd3);
        n = 1;
        while (!bus.frame_error && n < 100) begin
            tick();
            n++;
        end
        chk("to_lat", {31'd0, (n >= 16 && n <= 18)}, 32'd1);
        chk("to_nc0", {28'd0, bus.nibble_count}, 32'd0);
        chk("to_wo", bus.word_out, 32'h76543210);
        tick();
        chk("to_pulse", {31'd0, bus.frame_error}, 32'd0);
        send_word(32'hCAFEF00D, 1'b0);
        chk("to_next_wo", bus.word_out, 32'hCAFEF00D);

        // Reset mid-word with character_done high, pending word unacked
        for (int i = 0; i < 4; i++)
            send_nib(4'h9);
        bus.go = 1'b1;
        bus.character = 4'h9;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.character_done && n < 40);
        chk("mr_cd_hi", {31'd0, bus.character_done}, 32'd1);
        reset = 1'b1;
        bus.go = 1'b0;
        tick();
        reset = 1'b0;
        chk("mr_cd", {31'd0, bus.character_done}, 32'd0);
        chk("mr_wv", {31'd0, bus.word_valid}, 32'd0);
        chk("mr_wo", bus.word_out, 32'd0);
        chk("mr_nc", {28'd0, bus.nibble_count}, 32'd0);
        send_word(32'h00000001, 1'b0);
        chk("mr_next_wo", bus.word_out, 32'h00000001);
        chk("mr_next_wv", {31'd0, bus.word_valid}, 32'd1);

        // Ack coinciding with the last nibble
        w = 32'hA5A5A5A5;
        for (int i = 0; i < 7; i++)
            send_nib(w[4*i +: 4]);
        chk("sim_wv_pre", {31'd0, bus.word_valid}, 32'd1);
        bus.go = 1'b1;
        bus.character = w[31:28];
        bus.word_ack = 1'b1;
        tick();
        bus.word_ack = 1'b0;
        chk("sim_cd", {31'd0, bus.character_done}, 32'd1);
        chk("sim_wv", {31'd0, bus.word_valid}, 32'd1);
        chk("sim_wo", bus.word_out, 32'hA5A5A5A5);
        bus.go = 1'b0;
        tick();
        chk("sim_fall", {31'd0, bus.character_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
